return_stack: RTL

//  LIFO return-address stack that serves the control unit's push/pop requests.

---
 rtl/return_stack.sv | 85 ++++++++
 1 files changed

// File: rtl/return_stack.sv
// return_stack: LIFO return-address stack for subroutine call/return.
//   push saves ret_in (PC+1) on top. pop removes the top entry. top_out is a
//   combinational read, so the PC mux can take the return address in the pop
//   cycle itself.
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   push, pop, ret_in      stack requests and the address to store
//   clr_err                synchronous clear of the sticky error flags
//   top_out                current top entry, 0 while empty
//   empty, full, count     occupancy (empty/full decoded from count)
//   overflow, underflow    sticky error flags
module return_stack #(
  parameter int AW    = 10,
  parameter int DEPTH = 16,
  parameter int CW    = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] ret_in,
  input  logic          clr_err,
  output logic [AW-1:0] top_out,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count,
  output logic          overflow,
  output logic          underflow
);

  localparam int IW = $clog2(DEPTH);

  logic [AW-1:0] mem [DEPTH];

  logic [IW-1:0] top_idx;
  logic [IW-1:0] wr_idx;
  logic          do_push;
  logic          do_pop;
  logic          do_replace;
  logic          wr_en;
  logic          ov_set;
  logic          un_set;

  always_comb begin
    empty   = (count == '0);
    full    = (count == CW'(DEPTH));
    // Low index bits wrap 0 -> DEPTH-1, which is exactly the top slot when full.
    top_idx = count[IW-1:0] - IW'(1);
    top_out = empty ? '0 : mem[top_idx];

    // push+pop on an empty stack degenerates to a plain push.
    do_push    = push & (pop ? empty : ~full);
    do_pop     = pop & ~push & ~empty;
    do_replace = push & pop & ~empty;

    wr_en  = ~reset & (do_push | do_replace);
    wr_idx = do_replace ? top_idx : count[IW-1:0];

    ov_set = push & ~pop & full;
    un_set = pop & ~push & empty;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (do_push)
        count <= count + CW'(1);
      else if (do_pop)
        count <= count - CW'(1);
      // A new error in the same cycle as clr_err keeps the flag set.
      overflow  <= ov_set | (overflow & ~clr_err);
      underflow <= un_set | (underflow & ~clr_err);
    end
  end

  // Storage is not reset; empty masks stale contents on top_out.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_idx] <= ret_in;
  end

endmodule
